// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button conditioning block.
// Default cycle counts assume a 27 MHz system clock.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED,
    HELD
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;
  localparam int DEFAULT_LONG_CYCLES     = 13500000;
  localparam int DEFAULT_REPEAT_CYCLES   = 2700000;

  // Counter width able to hold 0..n, never narrower than one bit so a zero count stays legal.
  function automatic int cntWidth(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, debounce counter, press/long/repeat FSM.
// All outputs are registered and active-high.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat_pulse
);

  localparam int DBW = cntWidth(DEBOUNCE_CYCLES);
  localparam int HW  = cntWidth(LONG_CYCLES);
  localparam int RW  = cntWidth(REPEAT_CYCLES);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0]  REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic           r_sync1;
  logic           r_sync2;
  logic [DBW-1:0] r_dbCnt;
  logic           r_level;
  logic           r_press;
  logic           r_release;

  btn_state_t     r_state;
  logic [HW-1:0]  r_holdCnt;
  logic [RW-1:0]  r_repCnt;
  logic           r_long;
  logic           r_rep;

  logic w_raw;
  logic w_accept;
  logic w_rise;
  logic w_fall;

  assign w_raw    = ~r_sync2;
  assign w_accept = (w_raw != r_level) && (r_dbCnt == DB_LAST);
  assign w_rise   = w_accept & w_raw;
  assign w_fall   = w_accept & ~w_raw;

  // Synchronizer resets to the unpressed pin level; a level change needs an unbroken run of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_dbCnt   <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn_n;
      r_sync2   <= r_sync1;
      r_press   <= w_rise;
      r_release <= w_fall;
      if (w_raw == r_level) begin
        r_dbCnt <= '0;
      end else if (w_accept) begin
        r_dbCnt <= '0;
        r_level <= w_raw;
      end else begin
        r_dbCnt <= r_dbCnt + DBW'(1);
      end
    end
  end

  // FSM reacts on the same edge the debounced level changes, so a fall always beats a due long/repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RELEASED;
      r_holdCnt <= '0;
      r_repCnt  <= '0;
      r_long    <= 1'b0;
      r_rep     <= 1'b0;
    end else begin
      r_long <= 1'b0;
      r_rep  <= 1'b0;
      unique case (r_state)
        RELEASED: begin
          if (w_rise) begin
            r_state   <= PRESSED;
            r_holdCnt <= '0;
          end
        end
        PRESSED: begin
          if (w_fall) begin
            r_state <= RELEASED;
          end else if (r_holdCnt == HOLD_LAST) begin
            r_long   <= 1'b1;
            r_state  <= HELD;
            r_repCnt <= '0;
          end else begin
            r_holdCnt <= r_holdCnt + HW'(1);
          end
        end
        HELD: begin
          if (w_fall) begin
            r_state <= RELEASED;
          end else if (REPEAT_CYCLES != 0) begin
            if (r_repCnt == REP_LAST) begin
              r_rep    <= 1'b1;
              r_repCnt <= '0;
            end else begin
              r_repCnt <= r_repCnt + RW'(1);
            end
          end
        end
        default: r_state <= RELEASED;
      endcase
    end
  end

  assign o_level        = r_level;
  assign o_press        = r_press;
  assign o_release      = r_release;
  assign o_long_press   = r_long;
  assign o_repeat_pulse = r_rep;

endmodule

// File: rtl/button_debounce.sv
// Conditions N active-low raw button pins into clean levels and press/release/long/repeat pulses.
// Each bit of every port belongs to an independent button_channel.
module button_debounce
  import button_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] i_btn_n,
  output logic [N_BUTTONS-1:0] o_level,
  output logic [N_BUTTONS-1:0] o_press,
  output logic [N_BUTTONS-1:0] o_release,
  output logic [N_BUTTONS-1:0] o_long_press,
  output logic [N_BUTTONS-1:0] o_repeat_pulse
);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_badParams
    $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_channel
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .i_btn_n       (i_btn_n[i]),
      .o_level       (o_level[i]),
      .o_press       (o_press[i]),
      .o_release     (o_release[i]),
      .o_long_press  (o_long_press[i]),
      .o_repeat_pulse(o_repeat_pulse[i])
    );
  end

endmodule
